interp_upsampler: RTL

- Linear-interpolating upsampler. It is the expanding counterpart of the boxcar smoothing/decimating filter in the audio path.
- Accepts one signed sample per valid/ready handshake. Emits 2^s evenly spaced samples that ramp linearly from the previously accepted sample to the new one.
- Sits between a low-rate sample source and the full-rate DAC/processing chain.

---
 rtl/interp_upsampler_if.sv | 21 ++
 rtl/interp_upsampler.sv | 113 +++++++++++
 2 files changed

// File: rtl/interp_upsampler_if.sv
// rtl/interp_upsampler_if.sv - sample-in / sample-out handshake bundle for interp_upsampler
interface interp_upsampler_if #(
   parameter int BIT_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BIT_WIDTH-1:0] d;
   logic                 out_valid;
   logic                 out_ready;
   logic [BIT_WIDTH-1:0] q;

   modport master (
      output in_valid, d, out_ready,
      input  in_ready, out_valid, q
   );

   modport slave (
      input  in_valid, d, out_ready,
      output in_ready, out_valid, q
   );
endinterface

// File: rtl/interp_upsampler.sv
// rtl/interp_upsampler.sv - linear-interpolating 2^s upsampler; INTERP_ROUND_EN selects round-half-up output
// Each accepted sample produces 2^s outputs ramping from the previous sample to the new one.
module interp_upsampler #(
   parameter int BIT_WIDTH = 32,
   parameter int MAX_SHIFT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sclr,
   input  logic [2:0]          interp_sel,
   output logic                busy,
   interp_upsampler_if.slave   bus
);
   localparam int DW = BIT_WIDTH + 1;
   localparam int AW = BIT_WIDTH + 1 + MAX_SHIFT;
   localparam int SW = $clog2(MAX_SHIFT + 1);
   localparam int KW = MAX_SHIFT + 1;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                      r_state, w_state_nx;
   logic signed [BIT_WIDTH-1:0] r_prev, w_prev_nx;
   logic signed [DW-1:0]        r_delta, w_delta_nx;
   logic signed [AW-1:0]        r_acc, w_acc_nx;
   logic [KW-1:0]               r_k, w_k_nx;
   logic [SW-1:0]               r_s, w_s_nx;

   logic [SW-1:0]               w_sel_clip;
   logic signed [DW-1:0]        w_delta_new;
   logic signed [AW-1:0]        w_prev_acc;
   logic signed [AW-1:0]        w_delta_new_ext;
   logic signed [AW-1:0]        w_delta_ext;
   logic signed [AW-1:0]        w_acc_out;
   logic                        w_last;

   assign w_sel_clip = ({29'd0, interp_sel} > 32'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : SW'(interp_sel);

   // One extra bit so a full-scale negative-to-positive step cannot wrap.
   assign w_delta_new     = {bus.d[BIT_WIDTH-1], bus.d} - {r_prev[BIT_WIDTH-1], r_prev};
   assign w_prev_acc      = {{(AW-BIT_WIDTH){r_prev[BIT_WIDTH-1]}}, r_prev} <<< w_sel_clip;
   assign w_delta_new_ext = {{MAX_SHIFT{w_delta_new[DW-1]}}, w_delta_new};
   assign w_delta_ext     = {{MAX_SHIFT{r_delta[DW-1]}}, r_delta};
   assign w_last          = (r_k == (KW'(1) << r_s));

`ifdef INTERP_ROUND_EN
   // Half-LSB bias; evaluates to zero when r_s is 0, so pass-through is exact.
   assign w_acc_out = r_acc + ((AW'(1) << r_s) >> 1);
`else
   assign w_acc_out = r_acc;
`endif

   assign bus.q         = BIT_WIDTH'(w_acc_out >>> r_s);
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_RUN);
   assign busy          = (r_state == ST_RUN);

   always_comb begin
      w_state_nx = r_state;
      w_prev_nx  = r_prev;
      w_delta_nx = r_delta;
      w_acc_nx   = r_acc;
      w_k_nx     = r_k;
      w_s_nx     = r_s;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_state_nx = ST_RUN;
               w_s_nx     = w_sel_clip;
               w_delta_nx = w_delta_new;
               w_acc_nx   = w_prev_acc + w_delta_new_ext;
               w_k_nx     = KW'(1);
               w_prev_nx  = bus.d;
            end
         end
         ST_RUN: begin
            if (bus.out_ready) begin
               if (w_last) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_acc_nx = r_acc + w_delta_ext;
                  w_k_nx   = r_k + KW'(1);
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_prev  <= '0;
         r_delta <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_s     <= '0;
      end else if (sclr) begin
         r_state <= ST_IDLE;
         r_prev  <= '0;
         r_delta <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_s     <= '0;
      end else begin
         r_state <= w_state_nx;
         r_prev  <= w_prev_nx;
         r_delta <= w_delta_nx;
         r_acc   <= w_acc_nx;
         r_k     <= w_k_nx;
         r_s     <= w_s_nx;
      end
   end
endmodule
